// File: rtl/toy_trap_handler_pkg.sv
// Shared types and constants for the trap/debug responder and its tvec helper.
package toy_trap_handler_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int REG_WIDTH  = 32;

  localparam logic [2:0] DM_EBREAK  = 3'd1;
  localparam logic [2:0] DM_TRIGGER = 3'd2;
  localparam logic [2:0] DM_HALTREQ = 3'd3;
  localparam logic [2:0] DM_STEP    = 3'd4;

  localparam logic [31:0] MCAUSE_BREAK = 32'd3;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef enum logic {TH_IDLE, TH_REDIRECT} trap_hdl_state_t;
endpackage

// File: rtl/toy_trap_handler_tvec_calc.sv
// mtvec base/mode -> trap target. Vectored interrupts only when TOY_TRAP_VECTORED_EN is defined.
module toy_trap_tvec_calc
  import toy_trap_handler_pkg::*;
(
  input  logic [REG_WIDTH-1:0]  mtvec_i,
  input  logic [31:0]           cause_i,
  output logic [ADDR_WIDTH-1:0] tvec_o
);
  logic [ADDR_WIDTH-1:0] base;
  assign base = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};

`ifdef TOY_TRAP_VECTORED_EN
  // 4*cause[30:0] truncated to the address width, so cause bit 30 cannot reach the sum.
  logic unused_cause;
  assign unused_cause = cause_i[30];
  always_comb begin
    tvec_o = base;
    if ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && cause_i[31])
      tvec_o = base + {cause_i[ADDR_WIDTH-3:0], 2'b00};
  end
`else
  logic unused_cause;
  assign unused_cause = ^{cause_i, mtvec_i[1:0]};
  assign tvec_o = base;
`endif
endmodule

// File: rtl/toy_trap_handler.sv
// Trap/debug request responder: commits trap/debug CSRs and issues one fetch redirect per request.
// Optional vectored mtvec support via TOY_TRAP_VECTORED_EN (handled in toy_trap_tvec_calc).
module toy_trap_handler
  import toy_trap_handler_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DEBUG_ROM_ADDR  = 32'h0000_0800,
  parameter logic [ADDR_WIDTH-1:0] DEBUG_EXCP_ADDR = 32'h0000_0808
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_vld,
  output logic                  trap_rdy,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic [31:0]           trap_cause,
  input  logic [INST_WIDTH-1:0] trap_extra_info,
  input  logic                  trap_indebug,
  input  logic                  debug_vld,
  output logic                  debug_rdy,
  input  logic [2:0]            debug_cause,
  input  logic [ADDR_WIDTH-1:0] debug_pc,
  input  logic                  mret_vld,
  input  logic                  dret_vld,
  output logic                  ret_rdy,
  input  logic [REG_WIDTH-1:0]  csr_mtvec,
  output logic                  redirect_vld,
  input  logic                  redirect_rdy,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] csr_mepc,
  output logic [31:0]           csr_mcause,
  output logic [INST_WIDTH-1:0] csr_mtval,
  output logic                  csr_mie,
  output logic                  csr_mpie,
  output logic [ADDR_WIDTH-1:0] csr_dpc,
  output logic [2:0]            csr_dcsr_cause,
  output logic                  debug_mode_en
);
  trap_hdl_state_t       state_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, mepc_q, dpc_q, tvec;
  logic [31:0]           mcause_q;
  logic [INST_WIDTH-1:0] mtval_q;
  logic                  mie_q, mpie_q, dm_q;
  logic [2:0]            dcause_q;
  logic                  idle;

  toy_trap_tvec_calc u_tvec (
    .mtvec_i (csr_mtvec),
    .cause_i (trap_cause),
    .tvec_o  (tvec)
  );

  // Fixed priority debug > trap > ret; a losing source sees rdy low and holds.
  assign idle      = (state_q == TH_IDLE);
  assign debug_rdy = idle;
  assign trap_rdy  = idle && !debug_vld;
  assign ret_rdy   = idle && !debug_vld && !trap_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TH_IDLE;
      redirect_pc_q <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      dpc_q         <= '0;
      dcause_q      <= '0;
      dm_q          <= 1'b0;
    end else begin
      case (state_q)
        TH_IDLE: begin
          if (debug_vld) begin
            // Re-entry while already halted is swallowed without a redirect.
            if (!dm_q) begin
              dpc_q         <= debug_pc;
              dcause_q      <= debug_cause;
              dm_q          <= 1'b1;
              redirect_pc_q <= DEBUG_ROM_ADDR;
              state_q       <= TH_REDIRECT;
            end
          end else if (trap_vld) begin
            if (trap_indebug) begin
              redirect_pc_q <= DEBUG_EXCP_ADDR;
            end else begin
              mepc_q        <= trap_pc;
              mcause_q      <= trap_cause;
              mtval_q       <= trap_extra_info;
              mpie_q        <= mie_q;
              mie_q         <= 1'b0;
              redirect_pc_q <= tvec;
            end
            state_q <= TH_REDIRECT;
          end else if (dret_vld) begin
            if (dm_q) begin
              dm_q          <= 1'b0;
              redirect_pc_q <= dpc_q;
              state_q       <= TH_REDIRECT;
            end
          end else if (mret_vld) begin
            mie_q         <= mpie_q;
            mpie_q        <= 1'b1;
            redirect_pc_q <= mepc_q;
            state_q       <= TH_REDIRECT;
          end
        end
        TH_REDIRECT: if (redirect_rdy) state_q <= TH_IDLE;
        default:     state_q <= TH_IDLE;
      endcase
    end
  end

  assign redirect_vld   = (state_q == TH_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign csr_mepc       = mepc_q;
  assign csr_mcause     = mcause_q;
  assign csr_mtval      = mtval_q;
  assign csr_mie        = mie_q;
  assign csr_mpie       = mpie_q;
  assign csr_dpc        = dpc_q;
  assign csr_dcsr_cause = dcause_q;
  assign debug_mode_en  = dm_q;
endmodule

// File: tb/tb_toy_trap_handler.sv
// Directed bench for toy_trap_handler: priority, CSR commit, redirect stall, dret/mret, vectored tvec, reset.
module tb_toy_trap_handler;
  logic        clk = 1'b0;
  logic        rst;
  logic        trap_vld, trap_rdy, trap_indebug;
  logic [31:0] trap_pc, trap_cause, trap_extra_info;
  logic        debug_vld, debug_rdy;
  logic [2:0]  debug_cause;
  logic [31:0] debug_pc;
  logic        mret_vld, dret_vld, ret_rdy;
  logic [31:0] csr_mtvec;
  logic        redirect_vld, redirect_rdy;
  logic [31:0] redirect_pc, csr_mepc, csr_mcause, csr_mtval, csr_dpc;
  logic        csr_mie, csr_mpie, debug_mode_en;
  logic [2:0]  csr_dcsr_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toy_trap_handler dut (
    .clk(clk), .rst(rst),
    .trap_vld(trap_vld), .trap_rdy(trap_rdy), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_extra_info(trap_extra_info), .trap_indebug(trap_indebug),
    .debug_vld(debug_vld), .debug_rdy(debug_rdy), .debug_cause(debug_cause), .debug_pc(debug_pc),
    .mret_vld(mret_vld), .dret_vld(dret_vld), .ret_rdy(ret_rdy),
    .csr_mtvec(csr_mtvec),
    .redirect_vld(redirect_vld), .redirect_rdy(redirect_rdy), .redirect_pc(redirect_pc),
    .csr_mepc(csr_mepc), .csr_mcause(csr_mcause), .csr_mtval(csr_mtval),
    .csr_mie(csr_mie), .csr_mpie(csr_mpie), .csr_dpc(csr_dpc),
    .csr_dcsr_cause(csr_dcsr_cause), .debug_mode_en(debug_mode_en)
  );

  task automatic test_reset();
    rst = 1'b1; trap_vld = 0; trap_indebug = 0; trap_pc = 0; trap_cause = 0; trap_extra_info = 0;
    debug_vld = 0; debug_cause = 0; debug_pc = 0; mret_vld = 0; dret_vld = 0;
    csr_mtvec = 32'h200; redirect_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (redirect_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", redirect_vld); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", redirect_pc); end
    checks++; if ({csr_mepc, csr_mcause, csr_mtval, csr_dpc} !== 128'h0) begin failures++; $display("FAIL reset_csr got=%h/%h/%h/%h exp=0", csr_mepc, csr_mcause, csr_mtval, csr_dpc); end
    checks++; if ({csr_mie, csr_mpie, debug_mode_en, csr_dcsr_cause} !== 6'b0) begin failures++; $display("FAIL reset_bits got=%b%b%b/%0d exp=0", csr_mie, csr_mpie, debug_mode_en, csr_dcsr_cause); end
  endtask

  task automatic test_trap();
    @(negedge clk);
    trap_vld = 1; trap_cause = 32'd2; trap_pc = 32'h100; trap_extra_info = 32'hDEAD;
    #1;
    checks++; if (trap_rdy !== 1'b1) begin failures++; $display("FAIL trap_rdy got=%0b exp=1", trap_rdy); end
    @(negedge clk);
    trap_vld = 0;
    checks++; if (csr_mepc !== 32'h100 || csr_mcause !== 32'd2 || csr_mtval !== 32'hDEAD) begin failures++; $display("FAIL trap_csr got=%h/%h/%h exp=100/2/dead", csr_mepc, csr_mcause, csr_mtval); end
    checks++; if (csr_mie !== 1'b0 || csr_mpie !== 1'b0) begin failures++; $display("FAIL trap_mie got=%b%b exp=00", csr_mie, csr_mpie); end
    checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h200) begin failures++; $display("FAIL trap_redir got=%b/%h exp=1/200", redirect_vld, redirect_pc); end
    @(negedge clk);
    checks++; if (redirect_vld !== 1'b0) begin failures++; $display("FAIL trap_done got=%b exp=0", redirect_vld); end
  endtask

  // Debug and an in-debug trap collide; debug wins, the held trap follows.
  task automatic test_debug_priority();
    @(negedge clk);
    debug_vld = 1; debug_cause = 3'd3; debug_pc = 32'h140;
    trap_vld = 1; trap_indebug = 1; trap_cause = 32'd3; trap_pc = 32'h104; trap_extra_info = 32'hBEEF;
    #1;
    checks++; if (debug_rdy !== 1'b1 || trap_rdy !== 1'b0) begin failures++; $display("FAIL prio_rdy got=%b%b exp=10", debug_rdy, trap_rdy); end
    @(negedge clk);
    debug_vld = 0;
    checks++; if (csr_dpc !== 32'h140 || csr_dcsr_cause !== 3'd3 || debug_mode_en !== 1'b1) begin failures++; $display("FAIL dbg_csr got=%h/%0d/%b exp=140/3/1", csr_dpc, csr_dcsr_cause, debug_mode_en); end
    checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h800) begin failures++; $display("FAIL dbg_redir got=%b/%h exp=1/800", redirect_vld, redirect_pc); end
    checks++; if (trap_rdy !== 1'b0) begin failures++; $display("FAIL dbg_trap_blocked got=%b exp=0", trap_rdy); end
    @(negedge clk);
    checks++; if (trap_rdy !== 1'b1) begin failures++; $display("FAIL held_trap_rdy got=%b exp=1", trap_rdy); end
    @(negedge clk);
    trap_vld = 0; trap_indebug = 0;
    checks++; if (csr_mepc !== 32'h100 || csr_mcause !== 32'd2 || csr_mtval !== 32'hDEAD) begin failures++; $display("FAIL indebug_csr got=%h/%h/%h exp=100/2/dead", csr_mepc, csr_mcause, csr_mtval); end
    checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h808 || debug_mode_en !== 1'b1) begin failures++; $display("FAIL indebug_redir got=%b/%h/%b exp=1/808/1", redirect_vld, redirect_pc, debug_mode_en); end
    @(negedge clk);
    // Debug request while already halted: accepted, no redirect.
    debug_vld = 1; debug_cause = 3'd1; debug_pc = 32'h1F0;
    #1;
    checks++; if (debug_rdy !== 1'b1) begin failures++; $display("FAIL redebug_rdy got=%b exp=1", debug_rdy); end
    @(negedge clk);
    debug_vld = 0;
    checks++; if (redirect_vld !== 1'b0 || csr_dpc !== 32'h140 || csr_dcsr_cause !== 3'd3) begin failures++; $display("FAIL redebug_noop got=%b/%h/%0d exp=0/140/3", redirect_vld, csr_dpc, csr_dcsr_cause); end
  endtask

  task automatic test_dret();
    @(negedge clk);
    dret_vld = 1;
    #1;
    checks++; if (ret_rdy !== 1'b1) begin failures++; $display("FAIL dret_rdy got=%b exp=1", ret_rdy); end
    @(negedge clk);
    dret_vld = 0;
    checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h140 || debug_mode_en !== 1'b0) begin failures++; $display("FAIL dret got=%b/%h/%b exp=1/140/0", redirect_vld, redirect_pc, debug_mode_en); end
    @(negedge clk);
    dret_vld = 1;
    #1;
    checks++; if (ret_rdy !== 1'b1) begin failures++; $display("FAIL dret2_rdy got=%b exp=1", ret_rdy); end
    @(negedge clk);
    dret_vld = 0;
    checks++; if (redirect_vld !== 1'b0 || debug_mode_en !== 1'b0) begin failures++; $display("FAIL dret2_drop got=%b/%b exp=0/0", redirect_vld, debug_mode_en); end
  endtask

  task automatic test_mret_stall();
    // Two mrets from MIE=MPIE=0 arm MIE=1.
    repeat (2) begin
      @(negedge clk); mret_vld = 1;
      @(negedge clk); mret_vld = 0;
      @(negedge clk);
    end
    checks++; if (csr_mie !== 1'b1 || csr_mpie !== 1'b1 || redirect_pc !== 32'h100) begin failures++; $display("FAIL mret_arm got=%b%b/%h exp=11/100", csr_mie, csr_mpie, redirect_pc); end
    trap_vld = 1; trap_cause = 32'd5; trap_pc = 32'h180; trap_extra_info = 32'h0;
    @(negedge clk);
    trap_vld = 0;
    checks++; if (csr_mie !== 1'b0 || csr_mpie !== 1'b1 || csr_mepc !== 32'h180) begin failures++; $display("FAIL trap_mie1 got=%b%b/%h exp=01/180", csr_mie, csr_mpie, csr_mepc); end
    @(negedge clk);
    redirect_rdy = 0; mret_vld = 1;
    @(negedge clk);
    mret_vld = 0;
    checks++; if (csr_mie !== 1'b1 || csr_mpie !== 1'b1 || redirect_vld !== 1'b1 || redirect_pc !== 32'h180) begin failures++; $display("FAIL mret got=%b%b/%b/%h exp=11/1/180", csr_mie, csr_mpie, redirect_vld, redirect_pc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h180) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/180", i, redirect_vld, redirect_pc); end
      checks++; if ({trap_rdy, debug_rdy, ret_rdy} !== 3'b000) begin failures++; $display("FAIL stall_rdy[%0d] got=%b%b%b exp=000", i, trap_rdy, debug_rdy, ret_rdy); end
    end
    redirect_rdy = 1;
    @(negedge clk);
    checks++; if (redirect_vld !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", redirect_vld); end
  endtask

  task automatic test_vectored_and_reset();
    logic [31:0] exp_pc;
`ifdef TOY_TRAP_VECTORED_EN
    exp_pc = 32'h21C;
`else
    exp_pc = 32'h200;
`endif
    @(negedge clk);
    csr_mtvec = 32'h201; redirect_rdy = 0;
    trap_vld = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1C0; trap_extra_info = 32'h0;
    @(negedge clk);
    trap_vld = 0;
    checks++; if (redirect_vld !== 1'b1 || redirect_pc !== exp_pc || csr_mcause !== 32'h8000_0007) begin failures++; $display("FAIL vectored got=%b/%h/%h exp=1/%h/80000007", redirect_vld, redirect_pc, csr_mcause, exp_pc); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (redirect_vld !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL mid_reset got=%b/%h exp=0/0", redirect_vld, redirect_pc); end
    checks++; if (csr_mepc !== 32'h0 || csr_mcause !== 32'h0 || csr_mie !== 1'b0 || csr_mpie !== 1'b0) begin failures++; $display("FAIL mid_reset_csr got=%h/%h/%b%b exp=0/0/00", csr_mepc, csr_mcause, csr_mie, csr_mpie); end
    redirect_rdy = 1; csr_mtvec = 32'h200;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_trap();
    test_debug_priority();
    test_dret();
    test_mret_stall();
    test_vectored_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
